mdr_mult_seq: RTL



---
 rtl/mdr_mult_seq.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mdr_mult_seq.sv
// Sequential shift-add multiplier: DW iterations of add-and-shift, product held until the next DONE.
// Optional build macro MDR_MULT_SIGNED_EN selects two's-complement operands (sign/magnitude around the core).
module mdr_mult_seq #(
    parameter int DW = 16,
    parameter int CW = $clog2(DW) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic [DW-1:0]   i_multiplicand,
    input  logic [DW-1:0]   i_multiplier,
    output logic            o_busy,
    output logic            o_done,
    output logic [2*DW-1:0] o_product
);

    // state  | meaning
    // IDLE   | waiting for i_start; operands captured on the accepting edge
    // LOAD   | accumulator <- {0, multiplier}, counter cleared
    // RUN    | one add-and-shift iteration per cycle, DW cycles
    // DONE   | product valid, o_done high for this cycle only
    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    localparam int PW = 2 * DW;

    state_t        state_q, state_d;
    logic          load_op, load_acc, run_step, finish;

    logic [DW-1:0] mcand_q, mplier_q;
    logic [DW-1:0] mcand_mag, mplier_mag;
    logic [PW-1:0] acc_q, acc_next;
    logic [DW:0]   sum;
    logic [CW-1:0] cnt_q;
    logic [PW-1:0] prod_fix;
    logic [PW-1:0] product_q;
    logic          busy_q, done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load_op  = 1'b0;
        load_acc = 1'b0;
        run_step = 1'b0;
        finish   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_LOAD;
                    load_op = 1'b1;
                end
            end
            S_LOAD: begin
                state_d  = S_RUN;
                load_acc = 1'b1;
            end
            S_RUN: begin
                run_step = 1'b1;
                if (cnt_q == CW'(DW - 1)) begin
                    state_d = S_DONE;
                    finish  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The add carry lands in hi[DW-1] after the shift, so the stored accumulator needs no extra bit.
    assign sum      = acc_q[0] ? ({1'b0, acc_q[PW-1:DW]} + {1'b0, mcand_q})
                               : {1'b0, acc_q[PW-1:DW]};
    assign acc_next = {sum, acc_q[DW-1:1]};

`ifdef MDR_MULT_SIGNED_EN
    logic sign_q;

    // Most-negative value maps onto itself, which is the correct unsigned magnitude.
    assign mcand_mag  = mcand_q[DW-1]  ? (~mcand_q  + DW'(1)) : mcand_q;
    assign mplier_mag = mplier_q[DW-1] ? (~mplier_q + DW'(1)) : mplier_q;
    assign prod_fix   = sign_q ? (~acc_next + PW'(1)) : acc_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sign_q <= 1'b0;
        end else if (load_acc) begin
            sign_q <= mcand_q[DW-1] ^ mplier_q[DW-1];
        end
    end
`else
    assign mcand_mag  = mcand_q;
    assign mplier_mag = mplier_q;
    assign prod_fix   = acc_next;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            if (load_op) begin
                mcand_q  <= i_multiplicand;
                mplier_q <= i_multiplier;
            end
            if (load_acc) begin
                mcand_q <= mcand_mag;
                acc_q   <= {{DW{1'b0}}, mplier_mag};
                cnt_q   <= '0;
            end
            if (run_step) begin
                acc_q <= acc_next;
                cnt_q <= cnt_q + CW'(1);
            end
            // Product is captured from the final iteration so it is valid on entry to DONE.
            if (finish) begin
                product_q <= prod_fix;
            end
            busy_q <= (state_d != S_IDLE);
            done_q <= (state_d == S_DONE);
        end
    end

    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_product = product_q;

endmodule
